jtag_tap_datapath: RTL

//  Consumer of tap_controller STATE: the JTAG instruction register plus the IDCODE, BYPASS and USER data registers.

---
 rtl/tap_pkg.sv | 27 ++
 rtl/jtag_shift_reg.sv | 24 ++
 rtl/jtag_tap_datapath.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encoding and instruction codes shared with tap_controller
package tap_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [3:0] INSTR_IDCODE = 4'b0001;
    localparam logic [3:0] INSTR_USER   = 4'b1000;
    localparam logic [3:0] INSTR_BYPASS = 4'b1111;

endpackage

// File: rtl/jtag_shift_reg.sv
// rtl/jtag_shift_reg.sv - capture/shift register, shifts right with TDI entering the MSB
module jtag_shift_reg #(
    parameter int W = 8
) (
    input  logic         TCLK,
    input  logic         TRST_N,
    input  logic         capture_en,
    input  logic         shift_en,
    input  logic [W-1:0] cap_val,
    input  logic         TDI,
    output logic [W-1:0] q
);

    always_ff @(posedge TCLK) begin
        if (!TRST_N) begin
            q <= '0;
        end else if (capture_en) begin
            q <= cap_val;
        end else if (shift_en) begin
            q <= {TDI, q[W-1:1]};
        end
    end

endmodule

// File: rtl/jtag_tap_datapath.sv
// rtl/jtag_tap_datapath.sv - JTAG IR plus IDCODE/BYPASS/USER data registers driven by TAP state
module jtag_tap_datapath
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
    parameter int          USER_WIDTH = 8
) (
    input  logic                  TCLK,
    input  logic                  TRST_N,
    input  tap_state_t            STATE,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [IR_WIDTH-1:0]   IR_OUT,
    input  logic [USER_WIDTH-1:0] USER_DR_IN,
    output logic [USER_WIDTH-1:0] USER_DR_OUT,
    output logic                  USER_UPDATE
);

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [USER_WIDTH-1:0] user_sr;
    logic [30:0]           idcode_unused;
    logic                  idcode_lsb;
    logic                  bypass;
    logic                  sel_idcode;
    logic                  sel_user;
    logic                  sel_bypass;

    // Any code that is neither IDCODE nor USER falls back to the 1-bit BYPASS register.
    assign sel_idcode = (IR_OUT == IR_WIDTH'(INSTR_IDCODE));
    assign sel_user   = (IR_OUT == IR_WIDTH'(INSTR_USER));
    assign sel_bypass = !sel_idcode && !sel_user;

    jtag_shift_reg #(.W(IR_WIDTH)) u_ir (
        .TCLK       (TCLK),
        .TRST_N     (TRST_N),
        .capture_en (STATE == CAPTURE_IR),
        .shift_en   (STATE == SHIFT_IR),
        .cap_val    (IR_WIDTH'(2'b01)),
        .TDI        (TDI),
        .q          (ir_sr)
    );

    jtag_shift_reg #(.W(32)) u_idcode (
        .TCLK       (TCLK),
        .TRST_N     (TRST_N),
        .capture_en ((STATE == CAPTURE_DR) && sel_idcode),
        .shift_en   ((STATE == SHIFT_DR) && sel_idcode),
        .cap_val    (IDCODE_VAL),
        .TDI        (TDI),
        .q          ({idcode_unused, idcode_lsb})
    );

    jtag_shift_reg #(.W(USER_WIDTH)) u_user (
        .TCLK       (TCLK),
        .TRST_N     (TRST_N),
        .capture_en ((STATE == CAPTURE_DR) && sel_user),
        .shift_en   ((STATE == SHIFT_DR) && sel_user),
        .cap_val    (USER_DR_IN),
        .TDI        (TDI),
        .q          (user_sr)
    );

    always_ff @(posedge TCLK) begin
        if (!TRST_N) begin
            bypass <= 1'b0;
        end else if (sel_bypass && (STATE == CAPTURE_DR)) begin
            bypass <= 1'b0;
        end else if (sel_bypass && (STATE == SHIFT_DR)) begin
            bypass <= TDI;
        end
    end

    always_ff @(posedge TCLK) begin
        if (!TRST_N) begin
            IR_OUT <= IR_WIDTH'(INSTR_IDCODE);
        end else if (STATE == TEST_LOGIC_RESET) begin
            IR_OUT <= IR_WIDTH'(INSTR_IDCODE);
        end else if (STATE == UPDATE_IR) begin
            IR_OUT <= ir_sr;
        end
    end

    // USER_DR_OUT survives IR changes; only a USER update or reset replaces it.
    always_ff @(posedge TCLK) begin
        if (!TRST_N) begin
            USER_DR_OUT <= '0;
            USER_UPDATE <= 1'b0;
        end else if ((STATE == UPDATE_DR) && sel_user) begin
            USER_DR_OUT <= user_sr;
            USER_UPDATE <= 1'b1;
        end else begin
            USER_UPDATE <= 1'b0;
        end
    end

    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        case (STATE)
            SHIFT_IR: begin
                TDO    = ir_sr[0];
                TDO_EN = 1'b1;
            end
            SHIFT_DR: begin
                TDO_EN = 1'b1;
                if (sel_idcode) begin
                    TDO = idcode_lsb;
                end else if (sel_user) begin
                    TDO = user_sr[0];
                end else begin
                    TDO = bypass;
                end
            end
            default: begin
                TDO    = 1'b0;
                TDO_EN = 1'b0;
            end
        endcase
    end

endmodule
